seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It drives one shared active-low segment bus and four active-low anode enables. Each digit is driven in turn, with a programmable dwell time and an anti-ghosting blank gap between digits. New digit values arrive through a valid/ready write port and are applied only at frame boundaries, so a frame never shows a half-updated value. The block sits between datapath status logic and the board display pins.

Parameters:
DIV, 100000, dwell per digit in clk cycles (>=2)
GHOST_CYC, 2, all-anodes-off cycles between digits (0 = no gap)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write may be accepted this cycle
wr_data  in  16  four hex digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3
wr_mask  in  4  per-digit enable; bit i=1 lights digit i
seg  out  7  active-low segments, seg[6]=g .. seg[0]=a
an  out  4  active-low anodes, an[i] drives digit i
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, active-high):
  - Scan state: state=SCAN, idx=0, cnt=0.
  - Display regs: disp_data=0, disp_mask=0.
  - Pending: pend_v=0.
  - Outputs: seg=7'h7F, an=4'hF, wr_ready=1, frame_tick=0.
  - Deasserting reset mid-scan restarts at digit0.
- Scan FSM, two states:
  - SCAN: cnt counts 0..DIV-1. At cnt=DIV-1, cnt clears.
    - If GHOST_CYC>0, go to GAP.
    - Otherwise idx advances immediately and the FSM stays in SCAN.
  - GAP: cnt counts 0..GHOST_CYC-1. At the last count, cnt clears, idx advances, FSM returns to SCAN.
  - idx wraps 3->0. Frame period = 4*(DIV+GHOST_CYC) cycles.
- frame_tick is high for exactly the one cycle in which idx advances 3->0.
- Write handshake:
  - wr_ready = ~pend_v.
  - Accept when wr_valid & wr_ready. wr_data and wr_mask latch into the pending regs, and pend_v=1 from the next cycle.
  - On a frame_tick cycle with pend_v already 1: pending regs load into disp regs, and pend_v clears (wr_ready=1 the next cycle).
  - A write accepted in the same cycle as frame_tick is applied at the following boundary, not this one.
  - wr_valid while wr_ready=0 is ignored; the requester holds it.
- Output generation, registered with 1 cycle of latency after the state regs:
  - an[idx]=0 only when state=SCAN and disp_mask[idx]=1. All other anodes are 1, and all are 1 during GAP.
  - seg = hex decode of disp_data[idx] when that digit is lit, else 7'h7F.
  - Decode table, 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- Never more than one an bit low in any cycle.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: a lit digit i>0 is additionally blanked (an=1, seg=7F) when disp_data digit i and every higher digit are 0. Digit0 is never suppressed by this rule.
- Undefined: lighting depends on disp_mask only.

Test Plan:
Bench parameters are DIV=4 and GHOST_CYC=1, giving a 20-cycle frame.
- Reset check: assert reset mid-scan -> seg=7F, an=F, wr_ready=1, frame_tick=0 with no clock edge. Release -> digit0 window is first.
- Basic scan: write 16'h12AF with mask F, wait for the frame to apply -> per digit window, an=E/seg=0E, an=D/seg=08, an=B/seg=24, an=7/seg=79. Each window lasts 4 cycles, followed by 1 cycle of an=F.
- Frame-boundary update: write 16'h0000 mid-frame -> wr_ready=0 next cycle. Display unchanged until frame_tick. New values from digit0 of the next frame. wr_ready=1 the cycle after frame_tick.
- Collision: wr_valid asserted on a frame_tick cycle -> accepted, but applied only at the next frame_tick (20 cycles later). A second write in between is held off by wr_ready=0.
- Mask: mask 4'b0101 -> digits 1 and 3 keep an=F for their whole window. frame_tick period stays 20 cycles.
- LEAD_ZERO_BLANK_EN with 16'h0070, mask F -> digits 2 and 3 blank, digit1 seg=78, digit0 seg=40. Without the macro, digits 3 and 2 show 40.

Source files
------------

// File: rtl/seg_scan_if.sv
// Write port of the 7-segment scan controller: valid/ready handshake carrying four hex
// digits and a per-digit lighting mask.
interface seg_scan_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_data;
   logic [3:0]  wr_mask;

   modport master (output wr_valid, output wr_data, output wr_mask, input wr_ready);
   modport slave  (input wr_valid, input wr_data, input wr_mask, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with frame-boundary digit updates.
// Optional LEAD_ZERO_BLANK_EN macro blanks leading zero digits (digit0 always shown).
module seg_scan_ctrl #(
   parameter int unsigned DIV       = 100000,
   parameter int unsigned GHOST_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   seg_scan_if.slave   wr,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int unsigned CntMax = (DIV > GHOST_CYC) ? DIV : GHOST_CYC;
   localparam int unsigned CW     = $clog2(CntMax);
   localparam logic [CW-1:0] DivLast = CW'(DIV - 1);
   localparam logic [CW-1:0] GapLast = (GHOST_CYC > 0) ? CW'(GHOST_CYC - 1) : '0;

   typedef enum logic {StScan, StGap} state_e;

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          adv;

   logic [15:0]   disp_data_q, pend_data_q;
   logic [3:0]    disp_mask_q, pend_mask_q;
   logic          pend_v_q;

   logic [6:0]    seg_d;
   logic [3:0]    an_d;
   logic [3:0]    nib;
   logic          lit;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      unique case (h)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      adv     = 1'b0;
      unique case (state_q)
         StScan: begin
            if (cnt_q == DivLast) begin
               cnt_d = '0;
               if (GHOST_CYC > 0) state_d = StGap;
               else               adv     = 1'b1;
            end
         end
         default: begin
            if (cnt_q == GapLast) begin
               cnt_d   = '0;
               adv     = 1'b1;
               state_d = StScan;
            end
         end
      endcase
      idx_d = adv ? idx_q + 2'd1 : idx_q;
   end

   assign frame_tick  = adv && (idx_q == 2'd3);
   assign wr.wr_ready = ~pend_v_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StScan;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Accept and frame-boundary load are exclusive: accepting needs pend_v clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_v_q    <= 1'b0;
         pend_data_q <= '0;
         pend_mask_q <= '0;
         disp_data_q <= '0;
         disp_mask_q <= '0;
      end else if (wr.wr_valid && !pend_v_q) begin
         pend_v_q    <= 1'b1;
         pend_data_q <= wr.wr_data;
         pend_mask_q <= wr.wr_mask;
      end else if (frame_tick && pend_v_q) begin
         pend_v_q    <= 1'b0;
         disp_data_q <= pend_data_q;
         disp_mask_q <= pend_mask_q;
      end
   end

   always_comb begin
      nib   = disp_data_q[{idx_q, 2'b00} +: 4];
      lit   = (state_q == StScan) && disp_mask_q[idx_q];
`ifdef LEAD_ZERO_BLANK_EN
      unique case (idx_q)
         2'd1:    if (disp_data_q[15:4] == 12'h000) lit = 1'b0;
         2'd2:    if (disp_data_q[15:8] == 8'h00) lit = 1'b0;
         2'd3:    if (disp_data_q[15:12] == 4'h0) lit = 1'b0;
         default: ;
      endcase
`else
`endif
      an_d  = 4'hF;
      seg_d = 7'h7F;
      if (lit) begin
         an_d[idx_q] = 1'b0;
         seg_d       = hex7(nib);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= 7'h7F;
         an  <= 4'hF;
      end else begin
         seg <= seg_d;
         an  <= an_d;
      end
   end

endmodule
